// File: rtl/tm_pkg.sv
// Shared definitions for the template matcher: FSM state encoding,
// default geometry/pixel constants and a window-range helper.
package tm_pkg;

    localparam int TM_TPL_W    = 16;
    localparam int TM_TPL_H    = 16;
    localparam int TM_HALVING  = 3;
    localparam int TM_PIX_W    = 10;
    localparam int TM_COORD_W  = 13;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } tm_state_e;

    // True when a signed pixel offset is non-negative and its cell index
    // (offset / 2**halving) lies inside a template axis of 'cells' cells.
    function automatic logic tm_axis_in(input logic [TM_COORD_W:0] d,
                                        input int halving,
                                        input int cells);
        return (d[TM_COORD_W] == 1'b0) && ((32'(d) >> halving) < 32'(cells));
    endfunction

endpackage

// File: rtl/tm_template_ram.sv
// Template cell store: a flop array that powers up all-white, accepts
// writes only when the controller allows them, and returns a registered
// cell bit one cycle after the read address is presented.
module tm_template_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_allow,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);

    logic [DEPTH-1:0] mem_q;
    logic             rd_q;

    // Cell array: reset to all ones, writes outside the allowed states are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '1;
        end else if (wr_en && wr_allow) begin
            mem_q[wr_addr] <= wr_data;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Registered cell read feeding pipeline stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/template_matcher.sv
// Binary template matcher: counts pixels of one frame whose binarised
// value equals the template cell they fall into, over a window anchored
// at a latched origin, and reports the count once per armed frame.
// Optional overlay output is enabled by defining TEMPLATE_MATCHER_OVERLAY_EN;
// otherwise oOVL_VAL is tied to zero.
module template_matcher
    import tm_pkg::*;
#(
    parameter  int TPL_W   = TM_TPL_W,
    parameter  int TPL_H   = TM_TPL_H,
    parameter  int HALVING = TM_HALVING,
    parameter  int PIX_W   = TM_PIX_W,
    localparam int SCORE_W = $clog2(TPL_W * TPL_H * (4 ** HALVING)) + 1,
    localparam int ADDR_W  = $clog2(TPL_W * TPL_H)
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [12:0]        iX,
    input  logic [12:0]        iY,
    input  logic               iDVAL,
    input  logic               iFVAL,
    input  logic [PIX_W-1:0]   iPIX,
    input  logic [PIX_W-1:0]   iPIX_THR,
    input  logic [12:0]        iORG_X,
    input  logic [12:0]        iORG_Y,
    input  logic               iSTART,
    input  logic               iWR_EN,
    input  logic [ADDR_W-1:0]  iWR_ADDR,
    input  logic               iWR_DATA,
    input  logic [SCORE_W-1:0] iMATCH_THR,
    output logic               oBUSY,
    output logic [SCORE_W-1:0] oSCORE,
    output logic               oMATCH,
    output logic               oVALID,
    output logic [PIX_W-1:0]   oOVL_VAL
);

    tm_state_e state_q, state_d;
    logic      fval_q;
    logic      drain_cnt_q, drain_cnt_d;
    logic      fval_rise_s, fval_fall_s, wr_allow_s, enter_accum_s;

    logic [12:0]        org_x_q, org_y_q;
    logic [13:0]        dx_s, dy_s, dx_q, dy_q;
    logic               win_s, pbit_s;
    logic               v1_q, pbit1_q, v2_q, pbit2_q, tbit_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [SCORE_W-1:0] acc_q, score_q;
    logic               match_q, valid_q, busy_q;

    assign fval_rise_s   = iFVAL & ~fval_q;
    assign fval_fall_s   = ~iFVAL & fval_q;
    assign wr_allow_s    = (state_q == IDLE) || (state_q == REPORT);
    assign enter_accum_s = (state_q == ARMED) && (state_d == ACCUM);

    // Offsets from the latched origin; the extra top bit carries the sign
    assign dx_s   = {1'b0, iX} - {1'b0, org_x_q};
    assign dy_s   = {1'b0, iY} - {1'b0, org_y_q};
    assign win_s  = iDVAL && tm_axis_in(dx_s, HALVING, TPL_W) && tm_axis_in(dy_s, HALVING, TPL_H);
    assign pbit_s = (iPIX >= iPIX_THR);

    // Cell index of the stage-1 offsets; only meaningful when v1_q is set
    assign rd_addr_s = ADDR_W'(dx_q >> HALVING) + ADDR_W'(TPL_W) * ADDR_W'(dy_q >> HALVING);

    tm_template_ram #(
        .DEPTH  (TPL_W * TPL_H),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (iCLK),
        .rst      (iRST),
        .wr_allow (wr_allow_s),
        .wr_en    (iWR_EN),
        .wr_addr  (iWR_ADDR),
        .wr_data  (iWR_DATA),
        .rd_addr  (rd_addr_s),
        .rd_data  (tbit_s)
    );

    // Next-state logic: arm, frame-edge driven accumulate, 2-cycle drain, 1-cycle report
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (iSTART) state_d = ARMED;
                else        state_d = IDLE;
            end
            ARMED: begin
                if (fval_rise_s) state_d = ACCUM;
                else             state_d = ARMED;
            end
            ACCUM: begin
                if (fval_fall_s) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = REPORT;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and frame-valid history for edge detection
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
            fval_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fval_q      <= iFVAL;
        end
    end

    // Window origin is captured once per frame so mid-frame changes are ignored
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            org_x_q <= 13'd0;
            org_y_q <= 13'd0;
        end else if (enter_accum_s) begin
            org_x_q <= iORG_X;
            org_y_q <= iORG_Y;
        end else begin
            org_x_q <= org_x_q;
            org_y_q <= org_y_q;
        end
    end

    // Stages 1 and 2: offsets/in-window, then template bit (from RAM) and pixel bit
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dx_q    <= 14'd0;
            dy_q    <= 14'd0;
            v1_q    <= 1'b0;
            pbit1_q <= 1'b0;
            v2_q    <= 1'b0;
            pbit2_q <= 1'b0;
        end else begin
            dx_q    <= dx_s;
            dy_q    <= dy_s;
            v1_q    <= win_s && (state_q == ACCUM);
            pbit1_q <= pbit_s;
            v2_q    <= v1_q;
            pbit2_q <= pbit1_q;
        end
    end

    // Stage 3: count in-window pixels whose bit equals the template bit
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            acc_q <= '0;
        end else if (enter_accum_s) begin
            acc_q <= '0;
        end else if (v2_q && (tbit_s == pbit2_q)) begin
            acc_q <= acc_q + SCORE_W'(1);
        end else begin
            acc_q <= acc_q;
        end
    end

    // Result and status registers, aligned with the REPORT state
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            score_q <= '0;
            match_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == REPORT);
            busy_q  <= (state_d == ARMED) || (state_d == ACCUM);
            if ((state_d == REPORT) && (state_q != REPORT)) begin
                score_q <= acc_q;
                match_q <= (acc_q >= iMATCH_THR);
            end else begin
                score_q <= score_q;
                match_q <= match_q;
            end
        end
    end

    assign oBUSY  = busy_q;
    assign oSCORE = score_q;
    assign oMATCH = match_q;
    assign oVALID = valid_q;

`ifdef TEMPLATE_MATCHER_OVERLAY_EN
    logic             ovw1_q, ovw2_q;
    logic [PIX_W-1:0] pix1_q, pix2_q, ovl_q;

    // Overlay: paint template cells over the window, pass the pixel through elsewhere
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ovw1_q <= 1'b0;
            ovw2_q <= 1'b0;
            pix1_q <= '0;
            pix2_q <= '0;
            ovl_q  <= '0;
        end else begin
            ovw1_q <= win_s;
            ovw2_q <= ovw1_q;
            pix1_q <= iPIX;
            pix2_q <= pix1_q;
            if (ovw2_q) begin
                ovl_q <= tbit_s ? '1 : '0;
            end else begin
                ovl_q <= pix2_q;
            end
        end
    end

    assign oOVL_VAL = ovl_q;
`else
    assign oOVL_VAL = '0;
`endif

endmodule

// File: tb/tb_template_matcher.sv
// Self-checking bench for template_matcher: directed frames for the
// documented scores plus randomised frames scored by a reference model.
module tb_template_matcher;

    localparam int TPL_W = 16, TPL_H = 16, CELL = 8, PIX_W = 10, SCORE_W = 15, AW = 8;
    localparam int NCELL = TPL_W * TPL_H;

    logic               iCLK = 1'b0;
    logic               iRST = 1'b1;
    logic [12:0]        iX = 13'd0, iY = 13'd0, iORG_X = 13'd0, iORG_Y = 13'd0;
    logic               iDVAL = 1'b0, iFVAL = 1'b0, iSTART = 1'b0;
    logic [PIX_W-1:0]   iPIX = '0, iPIX_THR = '0;
    logic               iWR_EN = 1'b0, iWR_DATA = 1'b0;
    logic [AW-1:0]      iWR_ADDR = '0;
    logic [SCORE_W-1:0] iMATCH_THR = '0;
    logic               oBUSY, oMATCH, oVALID;
    logic [SCORE_W-1:0] oSCORE;
    logic [PIX_W-1:0]   oOVL_VAL;

    template_matcher dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iDVAL(iDVAL), .iFVAL(iFVAL),
        .iPIX(iPIX), .iPIX_THR(iPIX_THR), .iORG_X(iORG_X), .iORG_Y(iORG_Y),
        .iSTART(iSTART), .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
        .iMATCH_THR(iMATCH_THR), .oBUSY(oBUSY), .oSCORE(oSCORE), .oMATCH(oMATCH),
        .oVALID(oVALID), .oOVL_VAL(oOVL_VAL)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;
    bit tpl[NCELL];
    int qx[$], qy[$], qp[$];
    bit qd[$];
    int got_score, got_match, got_valid;
    int last_ox, last_oy, last_thr, last_exp;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_frame();
        qx.delete(); qy.delete(); qp.delete(); qd.delete();
    endtask

    task automatic push_pix(input int x, input int y, input int p, input bit d);
        qx.push_back(x); qy.push_back(y); qp.push_back(p); qd.push_back(d);
    endtask

    // Reference: a valid pixel at offset (dx,dy) counts when it lies inside the
    // TPL_W*CELL x TPL_H*CELL window and its threshold bit equals its cell bit.
    function automatic int model_score(input int ox, input int oy, input int thr);
        int cnt = 0;
        for (int i = 0; i < qx.size(); i++) begin
            int dx = qx[i] - ox;
            int dy = qy[i] - oy;
            if (qd[i] && dx >= 0 && dy >= 0 && dx / CELL < TPL_W && dy / CELL < TPL_H) begin
                if (tpl[dx / CELL + TPL_W * (dy / CELL)] == (qp[i] >= thr)) cnt++;
            end
        end
        return cnt;
    endfunction

    task automatic write_cell(input int a, input bit d);
        iWR_EN = 1'b1; iWR_ADDR = AW'(a); iWR_DATA = d;
        tick();
        iWR_EN = 1'b0;
    endtask

    task automatic arm();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b1) begin
            failures++;
            $display("FAIL arm_busy: got %0b expected 1", oBUSY);
        end
    endtask

    // Stream the queued pixels as one frame; origin inputs switch to mid values
    // after the frame starts, and optional template writes run alongside.
    task automatic run_frame(input int ox_mid, input int oy_mid, input bit wr_mid);
        iFVAL = 1'b1; iDVAL = 1'b0;
        tick();
        iORG_X = 13'(ox_mid); iORG_Y = 13'(oy_mid);
        for (int i = 0; i < qx.size(); i++) begin
            iX = 13'(qx[i]); iY = 13'(qy[i]); iPIX = PIX_W'(qp[i]); iDVAL = qd[i];
            if (wr_mid) begin
                iWR_EN = 1'b1; iWR_ADDR = AW'($urandom_range(0, NCELL - 1)); iWR_DATA = 1'($urandom_range(0, 1));
            end
            tick();
        end
        iDVAL = 1'b0; iFVAL = 1'b0; iWR_EN = 1'b0;
        tick();
    endtask

    task automatic wait_result(input bit start_in_report);
        bit pend = 1'b0;
        got_valid = 0; got_score = -1; got_match = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge iCLK);
            if (pend) begin iSTART = 1'b0; pend = 1'b0; end
            if (oVALID === 1'b1) begin
                got_valid++; got_score = int'(oSCORE); got_match = int'(oMATCH);
                if (start_in_report) begin iSTART = 1'b1; pend = 1'b1; end
            end
        end
        iSTART = 1'b0;
    endtask

    task automatic check_result(input string name, input int exp_score, input int exp_match);
        checks++;
        if (got_score != exp_score) begin
            failures++;
            $display("FAIL %s_score: got %0d expected %0d", name, got_score, exp_score);
        end
        checks++;
        if (got_valid != 1) begin
            failures++;
            $display("FAIL %s_valid_cycles: got %0d expected 1", name, got_valid);
        end
        if (exp_match >= 0) begin
            checks++;
            if (got_match != exp_match) begin
                failures++;
                $display("FAIL %s_match: got %0d expected %0d", name, got_match, exp_match);
            end
        end
        checks++;
        if (oBUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_after: got %0b expected 0", name, oBUSY);
        end
    endtask

    task automatic build_full(input int dark_x, input int dark_y);
        clear_frame();
        for (int y = 0; y < TPL_H * CELL; y++)
            for (int x = 0; x < TPL_W * CELL; x++)
                push_pix(x, y, (x == dark_x && y == dark_y) ? 0 : 1023, 1'b1);
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        tick(); tick();
        @(negedge iCLK);
        checks++;
        if ({oBUSY, oMATCH, oVALID} !== 3'b000 || oSCORE !== '0 || oOVL_VAL !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b match=%0b valid=%0b score=%0d ovl=%0d expected all 0",
                     oBUSY, oMATCH, oVALID, oSCORE, oOVL_VAL);
        end
        iRST = 1'b0;
        for (int c = 0; c < NCELL; c++) tpl[c] = 1'b1;
        tick();
    endtask

    task automatic test_full_window();
        iPIX_THR = 10'd512; iMATCH_THR = 15'd16384; iORG_X = 13'd0; iORG_Y = 13'd0;
        build_full(-1, -1);
        arm(); run_frame(0, 0, 1'b0); wait_result(1'b0);
        check_result("full_window", 16384, 1);
    endtask

    task automatic test_cell0_cleared();
        write_cell(0, 1'b0); tpl[0] = 1'b0;
        build_full(-1, -1);
        arm(); run_frame(0, 0, 1'b0); wait_result(1'b0);
        check_result("cell0_cleared", 16320, 0);
    endtask

    task automatic test_match_boundary();
        write_cell(0, 1'b1); tpl[0] = 1'b1;
        build_full(5, 5);
        arm(); run_frame(0, 0, 1'b0); wait_result(1'b0);
        check_result("score_16383", 16383, 0);
    endtask

    task automatic test_right_edge();
        iORG_X = 13'd600; iORG_Y = 13'd0;
        clear_frame();
        for (int y = 0; y < 128; y++)
            for (int x = 590; x < 640; x++) push_pix(x, y, 1023, 1'b1);
        arm(); run_frame(0, 0, 1'b0); wait_result(1'b0);
        check_result("right_edge", 5120, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NCELL; c++) begin
                bit b = 1'($urandom_range(0, 1));
                write_cell(c, b); tpl[c] = b;
            end
            last_ox = int'($urandom_range(0, 8000)); last_oy = int'($urandom_range(0, 8000));
            last_thr = int'($urandom_range(1, 1023));
            clear_frame();
            for (int i = 0; i < 500; i++) begin
                int x = last_ox + int'($urandom_range(0, 175)) - 24;
                int y = last_oy + int'($urandom_range(0, 175)) - 24;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 8191) x = 8191;
                if (y > 8191) y = 8191;
                push_pix(x, y, int'($urandom_range(0, 1023)), $urandom_range(0, 9) != 0);
            end
            last_exp = model_score(last_ox, last_oy, last_thr);
            iORG_X = 13'(last_ox); iORG_Y = 13'(last_oy); iPIX_THR = PIX_W'(last_thr);
            iMATCH_THR = SCORE_W'(last_exp + (r % 2));
            arm();
            run_frame(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)), 1'b0);
            wait_result(1'b0);
            check_result($sformatf("random%0d", r), last_exp, (r % 2 == 0) ? 1 : 0);
        end
    endtask

    task automatic test_accum_write_dropped();
        iORG_X = 13'(last_ox); iORG_Y = 13'(last_oy);
        arm(); run_frame(last_ox, last_oy, 1'b1); wait_result(1'b0);
        check_result("accum_write_dropped", last_exp, -1);
    endtask

    task automatic test_start_in_report();
        int e;
        iORG_X = 13'd40; iORG_Y = 13'd24; iPIX_THR = 10'd300;
        clear_frame();
        for (int i = 0; i < 60; i++)
            push_pix(40 + int'($urandom_range(0, 127)), 24 + int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 1023)), 1'b1);
        e = model_score(40, 24, 300);
        arm(); run_frame(40, 24, 1'b0); wait_result(1'b1);
        check_result("start_in_report", e, -1);
    endtask

    task automatic test_reset_mid_accum();
        iORG_X = 13'd0; iORG_Y = 13'd0; iPIX_THR = 10'd512;
        arm();
        iFVAL = 1'b1; tick();
        for (int i = 0; i < 100; i++) begin
            iX = 13'(i); iY = 13'd3; iPIX = 10'd1023; iDVAL = 1'b1;
            tick();
        end
        iRST = 1'b1;
        tick();
        @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b0 || oSCORE !== '0 || oVALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_accum: got busy=%0b score=%0d valid=%0b expected 0/0/0", oBUSY, oSCORE, oVALID);
        end
        iRST = 1'b0; iDVAL = 1'b0; iFVAL = 1'b0;
        for (int c = 0; c < NCELL; c++) tpl[c] = 1'b1;
        tick();
        clear_frame();
        for (int i = 0; i < 64; i++) push_pix(i, i, 1023, 1'b1);
        run_frame(0, 0, 1'b0); wait_result(1'b0);
        checks++;
        if (got_valid != 0) begin
            failures++;
            $display("FAIL no_start_no_valid: got %0d valid cycles expected 0", got_valid);
        end
        checks++;
        if (oSCORE !== '0 || oBUSY !== 1'b0) begin
            failures++;
            $display("FAIL no_start_idle: got score=%0d busy=%0b expected 0/0", oSCORE, oBUSY);
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_cell0_cleared();
        test_match_boundary();
        test_right_edge();
        test_random();
        test_accum_write_dropped();
        test_start_in_report();
        test_reset_mid_accum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/template_matcher.md
TEMPLATE_MATCHER -- requirements
Module: template_matcher

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- TPL_W, 16, template width in cells.
- TPL_H, 16, template height in cells.
- HALVING, 3, log2 of pixels per cell edge.
- PIX_W, 10, pixel grey width.
REQ-002 SCORE_W SHALL be a localparam equal to clog2(TPL_W*TPL_H*4**HALVING)+1, which is 15 at the defaults.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- iCLK, in, 1, the only clock.
- iRST, in, 1, asynchronous reset, active-high.
- iX, in, 13, pixel column.
- iY, in, 13, pixel row.
- iDVAL, in, 1, pixel valid.
- iFVAL, in, 1, frame valid.
- iPIX, in, PIX_W, grey pixel.
- iPIX_THR, in, PIX_W, binarise threshold; pixel bit = (iPIX >= iPIX_THR).
- iORG_X, in, 13, window origin column.
- iORG_Y, in, 13, window origin row.
- iSTART, in, 1, arm a measurement.
- iWR_EN, in, 1, template write strobe.
- iWR_ADDR, in, clog2(TPL_W*TPL_H), cell index = cx + TPL_W*cy.
- iWR_DATA, in, 1, cell bit (1 = white).
- iMATCH_THR, in, SCORE_W, match threshold.
- oBUSY, out, 1, high in ARMED and ACCUM.
- oSCORE, out, SCORE_W, matched-pixel count of the last frame.
- oMATCH, out, 1, oSCORE >= iMATCH_THR.
- oVALID, out, 1, one-cycle result strobe.
- oOVL_VAL, out, PIX_W, overlay pixel.

Function
REQ-004 The template SHALL be a TPL_W*TPL_H-bit flop array; a write SHALL take effect on the edge where iWR_EN=1, only in IDLE or REPORT; writes in ARMED or ACCUM SHALL be dropped.
REQ-005 The FSM SHALL be IDLE -> ARMED on iSTART; ARMED -> ACCUM on an iFVAL rising edge; ACCUM -> DRAIN on an iFVAL falling edge; DRAIN -> REPORT after 2 cycles; REPORT -> IDLE after 1 cycle.
REQ-006 The window origin SHALL be latched on the ARMED->ACCUM transition; origin changes mid-frame SHALL have no effect.
REQ-007 Pipeline stage 1 SHALL register dx=iX-orgX and dy=iY-orgY, with in-window = iDVAL & dx,dy >= 0 & (dx>>HALVING) < TPL_W & (dy>>HALVING) < TPL_H.
REQ-008 Pipeline stage 2 SHALL register the template bit at (dx>>HALVING)+TPL_W*(dy>>HALVING) and the pixel bit.
REQ-009 Pipeline stage 3 SHALL increment the accumulator when in-window and the bits are equal; accumulation latency is 3 cycles, drained by DRAIN.
REQ-010 The accumulator SHALL clear on entering ACCUM and SHALL NOT wrap, since its width covers the full window.
REQ-011 In REPORT, oSCORE SHALL take the accumulator and oMATCH the compare, both holding until the next REPORT; oVALID SHALL be high only in REPORT.
REQ-012 iSTART outside IDLE SHALL be ignored; iSTART in REPORT SHALL be ignored.
REQ-013 Pixels with iDVAL=0 or outside the window SHALL never count.
REQ-014 A frame ending with zero in-window pixels SHALL report oSCORE=0.

Reset
REQ-015 iRST SHALL force IDLE, oBUSY=0, oSCORE=0, oMATCH=0, oVALID=0, oOVL_VAL=0, clear the pipeline valids, and set all template bits to 1, whether or not a frame is in progress.

Configuration
REQ-016 With TEMPLATE_MATCHER_OVERLAY_EN defined, oOVL_VAL SHALL be the stage-2 template bit registered one more cycle: all ones if the bit is 1 and in-window, 0 if the bit is 0 and in-window, and iPIX delayed 3 cycles otherwise.
REQ-017 Without TEMPLATE_MATCHER_OVERLAY_EN, oOVL_VAL SHALL be constant 0 and the overlay pipeline SHALL be absent.

Structure
REQ-018 A shared package tm_pkg SHALL hold the state enum (IDLE, ARMED, ACCUM, DRAIN, REPORT) and the default TPL_W, TPL_H, HALVING and PIX_W constants.
REQ-019 The block SHALL contain one sub-module, tm_template_ram, which owns the flop array, write gating and the registered cell read.

Verification
REQ-020 After reset, with iSTART and a frame where every pixel is 1023 at iPIX_THR=512 over the full 128x128 window, the bench SHALL see oSCORE=16384 and oVALID for exactly 1 cycle.
REQ-021 With template cell 0 written to 0, the same frame SHALL give oSCORE=16320 (64 pixels fewer).
REQ-022 With iORG_X=600 on a 640-wide frame, only 40 columns are in-window, so the bench SHALL see oSCORE=40*128=5120.
REQ-023 An iWR_EN in ACCUM SHALL leave the template unchanged, confirmed by a repeat frame scoring the same as the previous frame.
REQ-024 iRST asserted mid-ACCUM SHALL return IDLE with oSCORE=0 and oBUSY=0 the next cycle; a following frame without iSTART SHALL produce no oVALID.
REQ-025 With iMATCH_THR=16384, a score of 16384 SHALL give oMATCH=1 and a score of 16383 SHALL give oMATCH=0.
